conv3d_channel_reduce: RTL and testbench
========================================

CONV3D_CHANNEL_REDUCE -- requirements
Module: conv3d_channel_reduce

Interface
REQ-001 Param DATA_WIDTH, default 16, signed two's-complement width of each partial sum, bias and output.
REQ-002 Param CHANNEL, default 3, number of per-channel 2D conv partial sums reduced per pixel; legal range 1..16.
REQ-003 Param IMG_WIDTH, default 56, output pixels per row.
REQ-004 Param IMG_HEIGHT, default 56, output rows per frame.
REQ-005 Param RELU_EN, default 1; 1 clamps negative results to 0, 0 passes them through.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 valid_in  input  1  data_in holds one pixel's CHANNEL partial sums.
REQ-009 data_in  input  CHANNEL*DATA_WIDTH  channel k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 bias_load  input  1  request to write bias_in into the bias register.
REQ-011 bias_in  input  DATA_WIDTH  signed bias value.
REQ-012 data_out  output  DATA_WIDTH  signed result pixel.
REQ-013 valid_out  output  1  data_out valid this cycle.
REQ-014 done  output  1  one-cycle pulse coincident with the last valid_out of a frame.
REQ-015 busy  output  1  high while any pipeline stage holds a valid pixel or the pixel counter is non-zero.
REQ-016 bias_err  output  1  one-cycle pulse when bias_load is rejected.

Function
REQ-017 Pipeline SHALL be a registered binary adder tree of S = ceil(log2(CHANNEL)) stages followed by one bias/saturate/ReLU stage; latency L = S+1 cycles (L=1 for CHANNEL=1).
REQ-018 The pixel accepted on cycle t (valid_in=1) SHALL appear on data_out with valid_out=1 on cycle t+L; no backpressure; one pixel per cycle sustained.
REQ-019 Odd operand counts at any tree level SHALL pass the unpaired operand through a register at that level, so all paths have equal latency.
REQ-020 Internal sums SHALL be sign-extended to DATA_WIDTH+ceil(log2(CHANNEL+1)) bits; no intermediate overflow.
REQ-021 Final stage: r = sum + bias; saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; if RELU_EN=1 and r<0, output 0.
REQ-022 data_out SHALL hold its last value when valid_out=0.
REQ-023 Bias register SHALL update only when bias_load=1 and busy=0 in that cycle; otherwise the register is unchanged and bias_err=1 next cycle.
REQ-024 bias_load accepted on the same cycle as the first pixel of a frame (busy=0) SHALL apply the new bias to that pixel.
REQ-025 Pixel counter (0..IMG_WIDTH*IMG_HEIGHT-1) SHALL increment on each valid_out; on valid_out at count IMG_WIDTH*IMG_HEIGHT-1, done=1 and counter wraps to 0 on the next edge.
REQ-026 Gaps in valid_in SHALL propagate as gaps in valid_out; counter holds across gaps.
REQ-027 A new frame SHALL be accepted on the cycle after done with no idle cycle required.

Reset
REQ-028 On reset=1 at a clock edge: all stage valid bits, valid_out, done, bias_err, busy, pixel counter, bias register and data_out SHALL become 0.
REQ-029 Reset asserted mid-frame SHALL discard all in-flight pixels; no valid_out may appear for pixels accepted before or during the reset cycle.
REQ-030 Inputs SHALL be ignored while reset=1.

Verification (DATA_WIDTH=16, CHANNEL=3, IMG 2x2, L=3 unless stated)
REQ-031 Reset: hold reset 2 cycles with valid_in=1 -> all outputs 0; no valid_out for 3 cycles after release.
REQ-032 Basic: bias_load 5, then pixel {10,20,-7} at t -> data_out=28, valid_out=1 at t+3.
REQ-033 ReLU/sat: {-100,20,30}, bias 0 -> 0 (RELU_EN=1), -50 (RELU_EN=0); {32767,32767,1} -> 32767; {-32768,-32768,0}, RELU_EN=0 -> -32768.
REQ-034 Frame: 8 back-to-back pixels -> done pulses with 4th and 8th valid_out; counter 0 after each; bias_load 9 mid-frame -> bias_err pulse, results still use old bias.
REQ-035 Reset mid-frame after 2 pixels accepted -> no valid_out for them; next 4 pixels give done on 4th output.
REQ-036 CHANNEL=1 (L=1) and CHANNEL=5 (L=4): random pixels with gaps -> outputs match reference model at exact latency.

Source files
------------

// File: rtl/conv3d_channel_reduce_if.sv
// Pixel/bias bus for the channel-reduction stage of a 3D convolution.
// The master drives pixels and bias loads; the slave returns reduced pixels and status.
interface conv3d_channel_reduce_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNEL    = 3
);
  logic                            valid_in;
  logic [CHANNEL*DATA_WIDTH-1:0]   data_in;
  logic                            bias_load;
  logic signed [DATA_WIDTH-1:0]    bias_in;
  logic signed [DATA_WIDTH-1:0]    data_out;
  logic                            valid_out;
  logic                            done;
  logic                            busy;
  logic                            bias_err;

  modport master (
    output valid_in, data_in, bias_load, bias_in,
    input  data_out, valid_out, done, busy, bias_err
  );

  modport slave (
    input  valid_in, data_in, bias_load, bias_in,
    output data_out, valid_out, done, busy, bias_err
  );
endinterface

// File: rtl/conv3d_channel_reduce.sv
// Reduces CHANNEL per-channel partial sums of one output pixel through a
// registered binary adder tree, then adds bias, saturates and applies ReLU.
// Frame bookkeeping (pixel counter, done pulse, busy) sits on the output side.
module conv3d_channel_reduce #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNEL    = 3,
  parameter int IMG_WIDTH  = 56,
  parameter int IMG_HEIGHT = 56,
  parameter int RELU_EN    = 1
) (
  input logic                    clk,
  input logic                    reset,
  conv3d_channel_reduce_if.slave bus
);

  localparam int S   = $clog2(CHANNEL);
  localparam int SW  = DATA_WIDTH + $clog2(CHANNEL + 1);
  localparam int RW  = SW + 1;
  localparam int PIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int CW  = (PIX > 1) ? $clog2(PIX) : 1;
  localparam logic [CW-1:0] LAST_PIX = CW'(PIX - 1);
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  // Number of operands present at tree level l (level 0 is the raw channels).
  function automatic int lvl_cnt(input int l);
    return (CHANNEL + (1 << l) - 1) >> l;
  endfunction

  // Adder tree: level 0 sign-extends the inputs, every further level registers
  // pairwise sums; an unpaired operand is registered unchanged to keep latency equal.
  for (genvar l = 0; l <= S; l++) begin : g_lvl
    localparam int N = lvl_cnt(l);
    logic signed [SW-1:0] node_s [N];
    logic                 node_vld_s;
    logic                 any_vld_s;

    if (l == 0) begin : g_in
      for (genvar i = 0; i < N; i++) begin : g_ext
        assign node_s[i] = {{(SW-DATA_WIDTH){bus.data_in[i*DATA_WIDTH+DATA_WIDTH-1]}},
                            bus.data_in[i*DATA_WIDTH +: DATA_WIDTH]};
      end
      assign node_vld_s = bus.valid_in;
      assign any_vld_s  = node_vld_s;
    end else begin : g_add
      localparam int NP = lvl_cnt(l - 1);
      logic signed [SW-1:0] pair_s [N];
      logic signed [SW-1:0] sum_r  [N];
      logic                 vld_r;

      for (genvar i = 0; i < N; i++) begin : g_op
        if (2 * i + 1 < NP) begin : g_pair
          assign pair_s[i] = g_lvl[l-1].node_s[2*i] + g_lvl[l-1].node_s[2*i+1];
        end else begin : g_pass
          assign pair_s[i] = g_lvl[l-1].node_s[2*i];
        end
      end

      // Register this tree level and its valid bit; reset flushes in-flight pixels.
      always_ff @(posedge clk) begin
        if (reset) begin
          vld_r <= 1'b0;
          for (int i = 0; i < N; i++) sum_r[i] <= {SW{1'b0}};
        end else begin
          vld_r <= g_lvl[l-1].node_vld_s;
          for (int i = 0; i < N; i++) sum_r[i] <= pair_s[i];
        end
      end

      assign node_s     = sum_r;
      assign node_vld_s = vld_r;
      assign any_vld_s  = vld_r | g_lvl[l-1].any_vld_s;
    end
  end

  logic signed [SW-1:0]         sum_s;
  logic                         fin_vld_s;
  logic                         any_vld_s;
  logic signed [DATA_WIDTH-1:0] bias_r;
  logic signed [DATA_WIDTH-1:0] bias_eff_s;
  logic                         bias_take_s;
  logic signed [RW-1:0]         res_s;
  logic signed [DATA_WIDTH-1:0] sat_s;
  logic signed [DATA_WIDTH-1:0] dout_nxt_s;
  logic signed [DATA_WIDTH-1:0] dout_r;
  logic                         valid_out_r;
  logic                         done_r;
  logic                         busy_r;
  logic                         bias_err_r;
  logic [CW-1:0]                cnt_r;
  logic [CW-1:0]                cnt_nxt_s;

  assign sum_s     = g_lvl[S].node_s[0];
  assign fin_vld_s = g_lvl[S].node_vld_s;
  // Any pixel that will sit in a tree register or the output register after this edge.
  assign any_vld_s = g_lvl[S].any_vld_s;

  // A bias written while idle also reaches a pixel entering the final stage in the
  // same cycle, which matters when the tree has no register levels.
  assign bias_take_s = bus.bias_load & ~busy_r;
  assign bias_eff_s  = bias_take_s ? bus.bias_in : bias_r;

  // Final stage arithmetic: bias add, saturation to DATA_WIDTH, optional ReLU.
  always_comb begin
    res_s = {sum_s[SW-1], sum_s} + {{(RW-DATA_WIDTH){bias_eff_s[DATA_WIDTH-1]}}, bias_eff_s};
    if (res_s > SAT_MAX) begin
      sat_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (res_s < SAT_MIN) begin
      sat_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sat_s = res_s[DATA_WIDTH-1:0];
    end
    if ((RELU_EN != 0) && sat_s[DATA_WIDTH-1]) begin
      dout_nxt_s = {DATA_WIDTH{1'b0}};
    end else begin
      dout_nxt_s = sat_s;
    end
  end

  // Pixel counter advances after every emitted pixel and wraps after the frame's last one.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (valid_out_r) begin
      if (cnt_r == LAST_PIX) begin
        cnt_nxt_s = {CW{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Output, frame status and bias registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_r      <= {DATA_WIDTH{1'b0}};
      valid_out_r <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      bias_err_r  <= 1'b0;
      bias_r      <= {DATA_WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
    end else begin
      valid_out_r <= fin_vld_s;
      done_r      <= fin_vld_s && (cnt_nxt_s == LAST_PIX);
      if (fin_vld_s) begin
        dout_r <= dout_nxt_s;
      end
      cnt_r      <= cnt_nxt_s;
      busy_r     <= any_vld_s | (cnt_nxt_s != {CW{1'b0}});
      bias_err_r <= bus.bias_load & busy_r;
      if (bias_take_s) begin
        bias_r <= bus.bias_in;
      end
    end
  end

  assign bus.data_out  = dout_r;
  assign bus.valid_out = valid_out_r;
  assign bus.done      = done_r;
  assign bus.busy      = busy_r;
  assign bus.bias_err  = bias_err_r;

endmodule

// File: tb/tb_conv3d_channel_reduce.sv
// Bench for conv3d_channel_reduce: four instances (CHANNEL 3 with/without ReLU,
// CHANNEL 1, CHANNEL 5), 2x2 frames, scoreboard queues checked at exact latency.
module tb_conv3d_channel_reduce;

  typedef struct {
    int   val;
    logic done;
    int   cyc;
  } exp_t;

  localparam int CHN  [4] = '{3, 3, 1, 5};
  localparam int LAT  [4] = '{3, 3, 1, 4};
  localparam int RELU [4] = '{1, 0, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   pcnt [4];
  exp_t sbq [4][$];

  // group 0 drives instances a/b, group 1 drives c/d
  logic              g_vld  [2];
  logic signed [15:0] g_ch  [2][5];
  int                bias_m [2];

  logic               vo [4];
  logic signed [15:0] dq [4];
  logic               dn [4];
  logic               bz [4];
  logic               be [4];

  conv3d_channel_reduce_if #(.DATA_WIDTH(16), .CHANNEL(3)) if_a ();
  conv3d_channel_reduce_if #(.DATA_WIDTH(16), .CHANNEL(3)) if_b ();
  conv3d_channel_reduce_if #(.DATA_WIDTH(16), .CHANNEL(1)) if_c ();
  conv3d_channel_reduce_if #(.DATA_WIDTH(16), .CHANNEL(5)) if_d ();

  conv3d_channel_reduce #(.DATA_WIDTH(16), .CHANNEL(3), .IMG_WIDTH(2), .IMG_HEIGHT(2), .RELU_EN(1))
    u_a (.clk(clk), .reset(rst), .bus(if_a));
  conv3d_channel_reduce #(.DATA_WIDTH(16), .CHANNEL(3), .IMG_WIDTH(2), .IMG_HEIGHT(2), .RELU_EN(0))
    u_b (.clk(clk), .reset(rst), .bus(if_b));
  conv3d_channel_reduce #(.DATA_WIDTH(16), .CHANNEL(1), .IMG_WIDTH(2), .IMG_HEIGHT(2), .RELU_EN(0))
    u_c (.clk(clk), .reset(rst), .bus(if_c));
  conv3d_channel_reduce #(.DATA_WIDTH(16), .CHANNEL(5), .IMG_WIDTH(2), .IMG_HEIGHT(2), .RELU_EN(1))
    u_d (.clk(clk), .reset(rst), .bus(if_d));

  assign vo[0] = if_a.valid_out; assign dq[0] = if_a.data_out; assign dn[0] = if_a.done;
  assign bz[0] = if_a.busy;      assign be[0] = if_a.bias_err;
  assign vo[1] = if_b.valid_out; assign dq[1] = if_b.data_out; assign dn[1] = if_b.done;
  assign bz[1] = if_b.busy;      assign be[1] = if_b.bias_err;
  assign vo[2] = if_c.valid_out; assign dq[2] = if_c.data_out; assign dn[2] = if_c.done;
  assign bz[2] = if_c.busy;      assign be[2] = if_c.bias_err;
  assign vo[3] = if_d.valid_out; assign dq[3] = if_d.data_out; assign dn[3] = if_d.done;
  assign bz[3] = if_d.busy;      assign be[3] = if_d.bias_err;

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: sum of channels + bias, clamp to 16-bit, optional ReLU.
  function automatic int model(input int d, input int g);
    int s;
    s = bias_m[g];
    for (int k = 0; k < CHN[d]; k++) s += int'(g_ch[g][k]);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (RELU[d] != 0 && s < 0) s = 0;
    return s;
  endfunction

  // scoreboard push: every accepted pixel yields one expected output L cycles later
  always @(posedge clk) begin
    exp_t e;
    for (int d = 0; d < 4; d++) begin
      if (rst) begin
        sbq[d].delete();
        pcnt[d] = 0;
      end else if (g_vld[d/2]) begin
        e.val  = model(d, d / 2);
        e.done = ((pcnt[d] % 4) == 3);
        e.cyc  = cyc + LAT[d];
        sbq[d].push_back(e);
        pcnt[d] = pcnt[d] + 1;
      end
    end
  end

  // scoreboard pop and compare on the falling edge
  always @(negedge clk) begin
    exp_t e;
    logic signed [15:0] x16;
    for (int d = 0; d < 4; d++) begin
      if (vo[d] === 1'b1) begin
        n_vec++;
        if (sbq[d].size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid dut%0d: data_out=%0d at cycle %0d, required no output", d, dq[d], cyc);
        end else begin
          e = sbq[d].pop_front();
          x16 = e.val[15:0];
          if (dq[d] !== x16 || dn[d] !== e.done || cyc !== e.cyc) begin
            n_err++;
            $display("FAIL scoreboard dut%0d: data_out=%0d done=%b cycle=%0d, required %0d/%b/%0d",
                     d, dq[d], dn[d], cyc, x16, e.done, e.cyc);
          end
        end
      end else if (dn[d] === 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL done_without_valid dut%0d: done=1 valid_out=0 at cycle %0d, required done=0", d, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic v, input int c0, input int c1, input int c2, input logic bl, input int bv);
    g_vld[0] = v;
    g_ch[0][0] = c0[15:0];
    g_ch[0][1] = c1[15:0];
    g_ch[0][2] = c2[15:0];
    if_a.valid_in = v;  if_b.valid_in = v;
    if_a.data_in = {g_ch[0][2], g_ch[0][1], g_ch[0][0]};
    if_b.data_in = {g_ch[0][2], g_ch[0][1], g_ch[0][0]};
    if_a.bias_load = bl; if_b.bias_load = bl;
    if_a.bias_in = bv[15:0]; if_b.bias_in = bv[15:0];
  endtask

  // group 1 channel values come from g_ch[1] filled by the caller
  task automatic drv1(input logic v, input logic bl, input int bv);
    g_vld[1] = v;
    if_c.valid_in = v;  if_d.valid_in = v;
    if_c.data_in = g_ch[1][0];
    if_d.data_in = {g_ch[1][4], g_ch[1][3], g_ch[1][2], g_ch[1][1], g_ch[1][0]};
    if_c.bias_load = bl; if_d.bias_load = bl;
    if_c.bias_in = bv[15:0]; if_d.bias_in = bv[15:0];
  endtask

  task automatic wait_drain(input int g);
    for (int i = 0; i < 30; i++) begin
      if (sbq[2*g].size() == 0 && sbq[2*g+1].size() == 0) break;
      tick();
    end
    for (int d = 2 * g; d < 2 * g + 2; d++) begin
      n_vec++;
      if (sbq[d].size() != 0 || bz[d] !== 1'b0 || vo[d] !== 1'b0) begin
        n_err++;
        $display("FAIL drain_idle dut%0d: pending=%0d busy=%b valid_out=%b, required 0/0/0",
                 d, sbq[d].size(), bz[d], vo[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv0(1'b1, 1, 2, 3, 1'b1, 7);
    for (int k = 0; k < 5; k++) g_ch[1][k] = 16'(k + 1);
    drv1(1'b1, 1'b1, 7);
    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      n_vec++;
      if (vo[d] !== 1'b0 || dq[d] !== 16'sd0 || dn[d] !== 1'b0 || bz[d] !== 1'b0 || be[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state dut%0d: vo=%b dout=%0d done=%b busy=%b berr=%b, required all 0",
                 d, vo[d], dq[d], dn[d], bz[d], be[d]);
      end
    end
    rst = 1'b0;
    bias_m[0] = 0;
    bias_m[1] = 0;
    drv0(1'b0, 0, 0, 0, 1'b0, 0);
    drv1(1'b0, 1'b0, 0);
    for (int t = 0; t < 3; t++) begin
      tick();
      for (int d = 0; d < 4; d++) begin
        n_vec++;
        if (vo[d] !== 1'b0) begin
          n_err++;
          $display("FAIL post_reset_quiet dut%0d: valid_out=%b, required 0", d, vo[d]);
        end
      end
    end
  endtask

  task automatic test_basic();
    drv0(1'b0, 0, 0, 0, 1'b1, 5);
    bias_m[0] = 5;
    tick();
    n_vec++;
    if (be[0] !== 1'b0 || be[1] !== 1'b0) begin
      n_err++;
      $display("FAIL idle_bias_load: bias_err=%b/%b, required 0/0", be[0], be[1]);
    end
    drv0(1'b1, 10, 20, -7, 1'b0, 0);     tick();   // 28
    drv0(1'b1, 1, 1, 1, 1'b0, 0);        tick();
    drv0(1'b1, -3, 4, 5, 1'b0, 0);       tick();
    drv0(1'b1, 100, -200, 50, 1'b0, 0);  tick();   // -45
    drv0(1'b0, 0, 0, 0, 1'b0, 0);
    wait_drain(0);
    n_vec++;
    if (dq[0] !== 16'sd0 || dq[1] !== -16'sd45) begin
      n_err++;
      $display("FAIL hold_data_out: dout=%0d/%0d, required 0/-45", dq[0], dq[1]);
    end
  endtask

  task automatic test_relu_sat();
    drv0(1'b1, -100, 20, 30, 1'b1, 0);   // new bias applies to this pixel
    bias_m[0] = 0;
    tick();
    n_vec++;
    if (be[0] !== 1'b0) begin
      n_err++;
      $display("FAIL first_pixel_bias_load: bias_err=%b, required 0", be[0]);
    end
    drv0(1'b1, 32767, 32767, 1, 1'b0, 0);    tick();
    drv0(1'b1, -32768, -32768, 0, 1'b0, 0);  tick();
    drv0(1'b1, 1, 2, 3, 1'b0, 0);            tick();
    drv0(1'b0, 0, 0, 0, 1'b0, 0);
    wait_drain(0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drv0(1'b1, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 2000)) - 1000,
           int'($urandom_range(0, 2000)) - 1000, (i == 2), 9);
      tick();
      if (i == 2) begin
        n_vec++;
        if (be[0] !== 1'b1 || be[1] !== 1'b1) begin
          n_err++;
          $display("FAIL busy_bias_err: bias_err=%b/%b, required 1/1", be[0], be[1]);
        end
      end
      if (i == 3) begin
        n_vec++;
        if (be[0] !== 1'b0) begin
          n_err++;
          $display("FAIL bias_err_pulse: bias_err=%b, required 0", be[0]);
        end
      end
    end
    drv0(1'b0, 0, 0, 0, 1'b0, 0);
    wait_drain(0);
  endtask

  task automatic test_mid_reset();
    drv0(1'b0, 0, 0, 0, 1'b1, 3);
    bias_m[0] = 3;
    tick();
    drv0(1'b1, 11, 12, 13, 1'b0, 0);  tick();
    drv0(1'b1, 21, 22, 23, 1'b0, 0);  tick();
    rst = 1'b1;
    drv0(1'b1, 31, 32, 33, 1'b0, 0);
    tick();
    n_vec++;
    if (vo[0] !== 1'b0 || bz[0] !== 1'b0 || dq[0] !== 16'sd0) begin
      n_err++;
      $display("FAIL mid_reset_state: vo=%b busy=%b dout=%0d, required 0/0/0", vo[0], bz[0], dq[0]);
    end
    rst = 1'b0;
    bias_m[0] = 0;
    bias_m[1] = 0;
    drv0(1'b0, 0, 0, 0, 1'b0, 0);
    for (int t = 0; t < 4; t++) tick();
    for (int i = 0; i < 4; i++) begin
      drv0(1'b1, 40 * i, -7, i, 1'b0, 0);
      tick();
    end
    drv0(1'b0, 0, 0, 0, 1'b0, 0);
    wait_drain(0);
  endtask

  task automatic test_random_ch1_ch5();
    int bv;
    int t;
    for (int b = 0; b < 3; b++) begin
      bv = int'($urandom_range(0, 400)) - 200;
      for (int i = 0; i < 8; i++) begin
        for (int gap = 0; gap < 3; gap++) begin
          if ($urandom_range(0, 2) != 0) break;
          drv1(1'b0, 1'b0, 0);
          tick();
        end
        for (int k = 0; k < 5; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            g_ch[1][k] = 16'($urandom_range(0, 65535));
          end else begin
            t = int'($urandom_range(0, 4000)) - 2000;
            g_ch[1][k] = t[15:0];
          end
        end
        drv1(1'b1, (i == 0), bv);
        if (i == 0) bias_m[1] = bv;
        tick();
      end
      drv1(1'b0, 1'b0, 0);
      wait_drain(1);
    end
  endtask

  initial begin
    g_vld[0] = 1'b0;
    g_vld[1] = 1'b0;
    bias_m[0] = 0;
    bias_m[1] = 0;
    for (int k = 0; k < 5; k++) begin
      g_ch[0][k] = 16'sd0;
      g_ch[1][k] = 16'sd0;
    end
    drv0(1'b0, 0, 0, 0, 1'b0, 0);
    drv1(1'b0, 1'b0, 0);
    test_reset();
    test_basic();
    test_relu_sat();
    test_back_to_back();
    test_mid_reset();
    test_random_ch1_ch5();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
